// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel active-low PWM LED driver that ramps each duty toward a written target.
// Define RGB_PWM_GAMMA_EN to apply a square-law gamma between the current duty and the PWM compare.
module rgb_pwm_fader #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 4,
  parameter int SP_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                fade_en,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic                busy,
  output logic                period_tick
);

  // Counter runs 0..MAX-1 with MAX = 2^N-1, so the last count is 2^N-2.
  localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [SP_W-1:0]     STEP_LAST = SP_W'(STEP_PERIODS - 1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [SP_W-1:0]     r_step_cnt;
  logic [PWM_BITS-1:0] r_target [3];
  logic [PWM_BITS-1:0] r_cur    [3];
  logic [2:0]          r_led;
  logic                r_busy;
  logic                r_period_tick;

  logic                w_wrap;
  logic                w_step;
  logic [SP_W-1:0]     w_step_cnt_nxt;
  logic [PWM_BITS-1:0] w_target_nxt [3];
  logic [PWM_BITS-1:0] w_cur_nxt    [3];
  logic [PWM_BITS-1:0] w_eff        [3];
  logic                w_busy_nxt;

  assign w_wrap = (r_pwm_cnt == CNT_LAST);
  assign w_step = (r_step_cnt == STEP_LAST);

  always_comb begin
    w_step_cnt_nxt = r_step_cnt;
    if (w_wrap) begin
      if (!fade_en || w_step) begin
        w_step_cnt_nxt = '0;
      end else begin
        w_step_cnt_nxt = r_step_cnt + 1'b1;
      end
    end
  end

  // Duty moves only on the wrap edge; the wrap reads the pre-write target so a
  // write landing on the wrap is picked up one period later. busy tracks next state.
  always_comb begin
    w_busy_nxt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w_target_nxt[c] = r_target[c];
      if (wr_en && ((wr_sel == 2'(c)) || (wr_sel == 2'd3))) begin
        w_target_nxt[c] = wr_data;
      end
      w_cur_nxt[c] = r_cur[c];
      if (w_wrap) begin
        if (!fade_en) begin
          w_cur_nxt[c] = r_target[c];
        end else if (w_step) begin
          if (r_cur[c] < r_target[c]) begin
            w_cur_nxt[c] = r_cur[c] + 1'b1;
          end else if (r_cur[c] > r_target[c]) begin
            w_cur_nxt[c] = r_cur[c] - 1'b1;
          end
        end
      end
      w_busy_nxt = w_busy_nxt | (w_cur_nxt[c] != w_target_nxt[c]);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_eff
`ifdef RGB_PWM_GAMMA_EN
    localparam logic [2*PWM_BITS-1:0] SQ_ROUND = (2*PWM_BITS)'((1 << PWM_BITS) - 1);
    logic [2*PWM_BITS-1:0] w_sq;
    // (d*d + MAX) >> N keeps 0, 1 and MAX fixed; the sum never exceeds 2N bits.
    assign w_sq     = (2*PWM_BITS)'(r_cur[g]) * (2*PWM_BITS)'(r_cur[g]) + SQ_ROUND;
    assign w_eff[g] = PWM_BITS'(w_sq >> PWM_BITS);
`else
    assign w_eff[g] = r_cur[g];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt     <= '0;
      r_step_cnt    <= '0;
      r_led         <= 3'b111;
      r_busy        <= 1'b0;
      r_period_tick <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        r_target[c] <= '0;
        r_cur[c]    <= '0;
      end
    end else begin
      r_pwm_cnt     <= w_wrap ? '0 : r_pwm_cnt + 1'b1;
      r_step_cnt    <= w_step_cnt_nxt;
      r_busy        <= w_busy_nxt;
      r_period_tick <= w_wrap;
      for (int c = 0; c < 3; c++) begin
        r_target[c] <= w_target_nxt[c];
        r_cur[c]    <= w_cur_nxt[c];
        r_led[c]    <= ~(r_pwm_cnt < w_eff[c]);
      end
    end
  end

  assign LED_R       = r_led[0];
  assign LED_G       = r_led[1];
  assign LED_B       = r_led[2];
  assign busy        = r_busy;
  assign period_tick = r_period_tick;

endmodule
